// File: rtl/fetch_align_buf_if.sv
// rtl/fetch_align_buf_if.sv - fetch-side and decode-side handshake bundle for the fetch realign buffer
interface fetch_align_buf_if #(
    parameter int FETCH_W = 64
);
    logic               flush;
    logic [31:0]        flush_pc;
    logic               in_valid;
    logic               in_ready;
    logic [FETCH_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic               out_isrv16;
    logic [15:0]        out_raw16;
    logic [31:0]        out_pc;

    // master is the surrounding pipeline: fetch stage, decode stage and redirect logic
    modport master (
        output flush, flush_pc, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_instr, out_isrv16, out_raw16, out_pc
    );

    modport slave (
        input  flush, flush_pc, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_instr, out_isrv16, out_raw16, out_pc
    );
endinterface

// File: rtl/fetch_align_buf.sv
// rtl/fetch_align_buf.sv - halfword fetch queue that realigns RV32/RV16 instructions for decode
module fetch_align_buf #(
    parameter int FETCH_W = 64,
    parameter int DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_align_buf_if.slave bus
);
    localparam int HW = FETCH_W / 16;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(FETCH_W / 8) - 1;

    logic [15:0]   r_buf [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_head_pc;
    logic [SW-1:0] r_skip;

    logic [15:0]   w_h0;
    logic [15:0]   w_h1;
    logic          w_isrv16;
    logic          w_out_valid;
    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_push_size;
    logic [CW-1:0] w_pop_size;
    logic [CW-1:0] w_cnt_next;
    logic [PW-1:0] w_wr_idx [HW];
    logic [HW-1:0] w_wr_en;
    logic          w_unused_pc0;

    function automatic logic [31:0] rv16torv32(input logic [15:0] c);
        logic [31:0] r;
        logic [4:0]  rd_f;
        logic [4:0]  rs2_f;
        logic [4:0]  rdp;
        logic [4:0]  rs1p;
        logic [11:0] ci_imm;
        logic [11:0] ls_imm;
        logic [11:0] j_off;
        logic [12:0] b_off;
        rd_f   = c[11:7];
        rs2_f  = c[6:2];
        rdp    = {2'b01, c[4:2]};
        rs1p   = {2'b01, c[9:7]};
        ci_imm = {{7{c[12]}}, c[6:2]};
        ls_imm = {5'b0, c[5], c[12:10], c[6], 2'b00};
        j_off  = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
        b_off  = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
        // Reserved and FP encodings expand to all-zero, which decode treats as illegal
        r = 32'h0;
        case ({c[15:13], c[1:0]})
            5'b000_00: if (c[12:5] != 8'h0)
                           r = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
            5'b010_00: r = {ls_imm, rs1p, 3'b010, rdp, 7'h03};
            5'b110_00: r = {ls_imm[11:5], rdp, rs1p, 3'b010, ls_imm[4:0], 7'h23};
            5'b000_01: r = {ci_imm, rd_f, 3'b000, rd_f, 7'h13};
            5'b001_01: r = {j_off[11], j_off[10:1], j_off[11], {8{j_off[11]}}, 5'd1, 7'h6F};
            5'b010_01: r = {ci_imm, 5'd0, 3'b000, rd_f, 7'h13};
            5'b011_01: begin
                if (rd_f == 5'd2) begin
                    if ({c[12], c[6:2]} != 6'h0)
                        r = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'h13};
                end else if ({c[12], c[6:2]} != 6'h0) begin
                    r = {{15{c[12]}}, c[6:2], rd_f, 7'h37};
                end
            end
            5'b100_01: begin
                case (c[11:10])
                    2'b00:   if (!c[12]) r = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                    2'b01:   if (!c[12]) r = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                    2'b10:   r = {ci_imm, rs1p, 3'b111, rs1p, 7'h13};
                    default: begin
                        if (!c[12]) begin
                            case (c[6:5])
                                2'b00:   r = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                                2'b01:   r = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                                2'b10:   r = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                                default: r = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                            endcase
                        end
                    end
                endcase
            end
            5'b101_01: r = {j_off[11], j_off[10:1], j_off[11], {8{j_off[11]}}, 5'd0, 7'h6F};
            5'b110_01: r = {b_off[12], b_off[10:5], 5'd0, rs1p, 3'b000, b_off[4:1], b_off[11], 7'h63};
            5'b111_01: r = {b_off[12], b_off[10:5], 5'd0, rs1p, 3'b001, b_off[4:1], b_off[11], 7'h63};
            5'b000_10: if (!c[12]) r = {7'b0000000, c[6:2], rd_f, 3'b001, rd_f, 7'h13};
            5'b010_10: if (rd_f != 5'd0)
                           r = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd_f, 7'h03};
            5'b100_10: begin
                if (!c[12]) begin
                    if (rs2_f == 5'd0) begin
                        if (rd_f != 5'd0) r = {12'h0, rd_f, 3'b000, 5'd0, 7'h67};
                    end else begin
                        r = {7'b0000000, rs2_f, 5'd0, 3'b000, rd_f, 7'h33};
                    end
                end else begin
                    if (rs2_f == 5'd0 && rd_f == 5'd0) r = 32'h0010_0073;
                    else if (rs2_f == 5'd0)            r = {12'h0, rd_f, 3'b000, 5'd1, 7'h67};
                    else                               r = {7'b0000000, rs2_f, rd_f, 3'b000, rd_f, 7'h33};
                end
            end
            5'b110_10: r = {4'b0000, c[8:7], c[12], rs2_f, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
            default:   r = 32'h0;
        endcase
        return r;
    endfunction

    assign w_h0        = r_buf[r_rd_ptr];
    assign w_h1        = r_buf[r_rd_ptr + PW'(1)];
    assign w_isrv16    = (w_h0[1:0] != 2'b11);
    assign w_out_valid = ((r_cnt != '0) && w_isrv16) || (r_cnt >= CW'(2));
    assign w_in_ready  = (r_cnt <= CW'(DEPTH - HW));
    assign w_push      = bus.in_valid && w_in_ready && !bus.flush;
    assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;
    assign w_push_size = CW'(HW) - CW'(r_skip);
    assign w_pop_size  = w_isrv16 ? CW'(1) : CW'(2);
    assign w_cnt_next  = r_cnt + (w_push ? w_push_size : '0) - (w_pop ? w_pop_size : '0);
    assign w_unused_pc0 = bus.flush_pc[0];

    // The first word after a redirect drops its halfwords below the target; the rest pack from wr_ptr
    always_comb begin
        for (int k = 0; k < HW; k++) begin
            w_wr_en[k]  = w_push && (k >= int'(r_skip));
            w_wr_idx[k] = r_wr_ptr + PW'(k) - PW'(r_skip);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < HW; k++) begin
            if (w_wr_en[k]) r_buf[w_wr_idx[k]] <= bus.in_data[16*k +: 16];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_cnt     <= '0;
            r_head_pc <= '0;
            r_skip    <= '0;
        end else if (bus.flush) begin
            r_cnt     <= '0;
            r_rd_ptr  <= r_wr_ptr;
            r_head_pc <= {bus.flush_pc[31:1], 1'b0};
            r_skip    <= bus.flush_pc[SW:1];
        end else begin
            r_cnt <= w_cnt_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(w_push_size);
                r_skip   <= '0;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PW'(w_pop_size);
                r_head_pc <= r_head_pc + (w_isrv16 ? 32'd2 : 32'd4);
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_isrv16 = w_isrv16;
    assign bus.out_raw16  = w_h0;
    assign bus.out_pc     = r_head_pc;
    assign bus.out_instr  = w_isrv16 ? rv16torv32(w_h0) : {w_h1, w_h0};
endmodule

// File: tb/tb_fetch_align_buf.sv
// tb/tb_fetch_align_buf.sv - randomized bench for fetch_align_buf against a halfword-queue model
module tb_fetch_align_buf;
    localparam int FETCH_W = 64;
    localparam int DEPTH   = 8;
    localparam int HW      = FETCH_W / 16;
    localparam int WB      = FETCH_W / 8;

    // Hand-encoded compressed instructions and their 32-bit equivalents
    localparam logic [15:0] C16_RAW [10] = '{16'h0001, 16'h0085, 16'h852E, 16'h4080, 16'h8082,
                                             16'h952E, 16'h028E, 16'h6785, 16'hC044, 16'hA011};
    localparam logic [31:0] C16_EXP [10] = '{32'h00000013, 32'h00108093, 32'h00B00533, 32'h0004A403,
                                             32'h00008067, 32'h00B50533, 32'h00329293, 32'h000017B7,
                                             32'h00942223, 32'h0040006F};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_align_buf_if #(.FETCH_W(FETCH_W)) bus ();
    fetch_align_buf #(.FETCH_W(FETCH_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_hq [$];
    logic [31:0] m_pc;
    int          m_skip;
    logic [15:0] src [$];
    bit          gen_en;
    logic [31:0] log_pc [$];
    logic [31:0] log_instr [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic [31:0] expand(input logic [15:0] h);
        for (int i = 0; i < 10; i++) if (C16_RAW[i] == h) return C16_EXP[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic gen_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            src.push_back(C16_RAW[$urandom_range(0, 9)]);
        end else begin
            src.push_back({w[15:2], 2'b11});
            src.push_back(w[31:16]);
        end
    endtask

    task automatic model_reset();
        m_hq.delete();
        src.delete();
        m_pc   = 32'h0;
        m_skip = 0;
    endtask

    // One clock: drive at the falling edge, check outputs 1ns later, advance the model
    task automatic step(input bit f, input logic [31:0] fpc, input bit iv, input bit ordy);
        logic [FETCH_W-1:0] word;
        bit exp_rdy, exp_vld, rv16;
        if (iv) while (gen_en && src.size() < HW) gen_instr();
        word = '0;
        for (int k = 0; k < HW && k < src.size(); k++) word[16*k +: 16] = src[k];
        bus.flush = f; bus.flush_pc = fpc; bus.in_valid = iv; bus.in_data = word; bus.out_ready = ordy;
        #1;
        exp_rdy = (DEPTH - m_hq.size()) >= HW;
        rv16    = (m_hq.size() > 0) && (m_hq[0][1:0] != 2'b11);
        exp_vld = rv16 || (m_hq.size() >= 2);
        check("in_ready", bus.in_ready, exp_rdy);
        check("out_valid", bus.out_valid, exp_vld);
        check("out_pc", bus.out_pc, m_pc);
        if (exp_vld) begin
            check("out_isrv16", bus.out_isrv16, rv16);
            check("out_raw16", bus.out_raw16, m_hq[0]);
            check("out_instr", bus.out_instr, rv16 ? expand(m_hq[0]) : {m_hq[1], m_hq[0]});
        end
        if (f) begin
            m_hq.delete();
            src.delete();
            m_pc   = {fpc[31:1], 1'b0};
            m_skip = int'(fpc % WB) / 2;
            if (gen_en) repeat (m_skip) src.push_back(16'($urandom));
        end else begin
            if (exp_vld && ordy) begin
                log_pc.push_back(bus.out_pc);
                log_instr.push_back(bus.out_instr);
                void'(m_hq.pop_front());
                if (!rv16) void'(m_hq.pop_front());
                m_pc += rv16 ? 32'd2 : 32'd4;
            end
            if (iv && exp_rdy) begin
                for (int k = m_skip; k < HW; k++) m_hq.push_back(word[16*k +: 16]);
                m_skip = 0;
                repeat (HW) if (src.size() > 0) void'(src.pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic check_log(input string tag, input int n, input logic [31:0] pc0,
                             input logic [31:0] pcs [4], input logic [31:0] ins [4]);
        check({tag, "_count"}, log_pc.size(), n);
        for (int i = 0; i < n && i < log_pc.size(); i++) begin
            check({tag, "_pc"}, log_pc[i], pc0 + pcs[i]);
            check({tag, "_instr"}, log_instr[i], ins[i]);
        end
        log_pc.delete();
        log_instr.delete();
    endtask

    initial begin
        bus.flush = 1'b0; bus.flush_pc = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        gen_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_pc", bus.out_pc, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Four RV32 addi across two words at 0x100
        step(1'b1, 32'h100, 1'b0, 1'b0);
        repeat (4) begin src.push_back(16'h0013); src.push_back(16'h0000); end
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b1);
        repeat (5) step(1'b0, 0, 1'b0, 1'b1);
        check_log("t1", 4, 32'h100, '{0, 4, 8, 12}, '{32'h13, 32'h13, 32'h13, 32'h13});

        // Two c.nop then an RV32 addi in one word at 0x200
        step(1'b1, 32'h200, 1'b0, 1'b0);
        src = '{16'h0001, 16'h0001, 16'h0013, 16'h0000};
        step(1'b0, 0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 0, 1'b0, 1'b1);
        check_log("t2", 3, 32'h200, '{0, 2, 4, 0}, '{32'h13, 32'h13, 32'h13, 32'h0});

        // Redirect to 0x306: RV32 head straddles two words with a one-cycle gap between them
        step(1'b1, 32'h306, 1'b0, 1'b0);
        src = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0093, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        repeat (5) step(1'b0, 0, 1'b0, 1'b1);
        check_log("t3", 4, 32'h306, '{0, 4, 6, 8}, '{32'h93, 32'h13, 32'h13, 32'h13});

        // Back-pressure, then release; then flush while a valid instruction is offered
        gen_en = 1'b1;
        step(1'b1, 32'h1000, 1'b0, 1'b0);
        repeat (8)  step(1'b0, 0, 1'b1, 1'b0);
        repeat (20) step(1'b0, 0, 1'b1, 1'b1);
        step(1'b1, 32'h2002, 1'b1, 1'b1);
        #1;
        check("t5_out_valid", bus.out_valid, 0);
        check("t5_out_pc", bus.out_pc, 32'h2002);
        @(negedge clk);

        repeat (600) begin
            step($urandom_range(0, 39) == 0, 32'h4000 + 32'(2 * $urandom_range(0, 63)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset with five halfwords queued
        gen_en = 1'b0;
        step(1'b1, 32'h400, 1'b0, 1'b0);
        src = '{16'h0001, 16'h0013, 16'h0000, 16'h0001, 16'h0013, 16'h0000, 16'h0013, 16'h0000};
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        #1;
        check("t6_pre_in_ready", bus.in_ready, 0);
        check("t6_pre_out_valid", bus.out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_in_ready", bus.in_ready, 1);
        check("t6_out_pc", bus.out_pc, 0);
        model_reset();
        log_pc.delete();
        log_instr.delete();
        @(negedge clk);
        rst_n = 1'b1;
        gen_en = 1'b1;
        step(1'b1, 32'h500, 1'b0, 1'b0);
        repeat (100) step(1'b0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
